fx2_stream_mux: RTL and testbench

- Parametrised N-channel byte-stream arbiter that merges timetag sample, command-reply and future per-detector streams into the single FX2 IN data path.
- Successor to the fixed two-source sample/reply hookup. Each granted burst is prefixed with a channel header byte and terminated with an end-of-packet request.
- The host therefore sees one USB packet per burst, tagged with its source channel.
- Supports round-robin or fixed-priority arbitration, a burst-length cap and an idle timeout.

---
 rtl/fx2_stream_mux.sv | 162 ++++++++++++++++
 tb/tb_fx2_stream_mux.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fx2_stream_mux.sv
// N-channel byte-stream arbiter feeding the single FX2 IN data path.
// Each grant is sent as a header byte {4'hA, chan}, the payload, then a pktend request.
module fx2_stream_mux #(
  parameter int N_CH         = 2,
  parameter int DW           = 8,
  parameter int MAX_BURST    = 510,
  parameter int IDLE_TIMEOUT = 64,
  parameter int RR_MODE      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH*DW-1:0]   in_data,
  input  logic [N_CH-1:0]      in_rdy,
  input  logic [N_CH-1:0]      in_end,
  output logic [N_CH-1:0]      in_ack,
  output logic [7:0]           out_data,
  output logic                 out_rdy,
  output logic                 out_end,
  input  logic                 out_ack,
  output logic [3:0]           out_chan,
  output logic                 busy
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [16:0] MAX_B = 17'(MAX_BURST);
  localparam logic [16:0] IDLE_T = 17'(IDLE_TIMEOUT);

  // state  | meaning
  // IDLE   | no grant; pick a winner when any channel requests
  // HEADER | present channel header byte for the latched grant
  // STREAM | pass granted channel bytes straight through to the FX2 writer
  // CLOSE  | request pktend, then release the grant
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_STREAM = 2'd2,
    S_CLOSE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] grant;
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] rr_next;
  logic [CW-1:0] win;
  logic          any_req;
  logic [15:0]   burst_cnt;
  logic [15:0]   idle_cnt;
  logic [16:0]   burst_inc;
  logic [16:0]   idle_inc;
  logic          burst_hit;
  logic          idle_hit;
  logic          g_rdy;
  logic          g_end;
  logic [DW-1:0] g_data;
  logic          xfer;

  // Winner search: scan from rr_ptr (round-robin) or from 0 (fixed priority).
  always_comb begin
    logic          found;
    logic [CW-1:0] cand;
    int            idx;
    win     = '0;
    found   = 1'b0;
    cand    = '0;
    idx     = 0;
    any_req = |in_rdy;
    for (int i = 0; i < N_CH; i++) begin
      idx = (RR_MODE != 0) ? int'(rr_ptr) + i : i;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = CW'(idx);
      if (!found && in_rdy[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign g_rdy     = in_rdy[grant];
  assign g_end     = in_end[grant];
  assign g_data    = in_data[grant*DW +: DW];
  assign xfer      = (state == S_STREAM) && g_rdy && out_ack;
  assign burst_inc = {1'b0, burst_cnt} + 17'd1;
  assign idle_inc  = {1'b0, idle_cnt} + 17'd1;
  assign burst_hit = burst_inc >= MAX_B;
  assign idle_hit  = idle_inc >= IDLE_T;
  assign rr_next   = (int'(grant) >= N_CH - 1) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_req) state_nxt = S_HEADER;
      S_HEADER: if (out_ack) state_nxt = S_STREAM;
      S_STREAM: begin
        if (xfer && (g_end || burst_hit))
          state_nxt = S_CLOSE;
        else if (!g_rdy && idle_hit)
          state_nxt = S_CLOSE;
      end
      S_CLOSE:  if (out_ack) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ack   = '0;
    out_data = '0;
    out_rdy  = 1'b0;
    out_end  = 1'b0;
    out_chan = 4'(grant);
    busy     = (state != S_IDLE);
    case (state)
      S_HEADER: begin
        out_rdy  = 1'b1;
        out_data = {4'hA, out_chan};
      end
      S_STREAM: begin
        out_rdy       = g_rdy;
        out_data      = g_data;
        in_ack[grant] = g_rdy && out_ack;
      end
      S_CLOSE:  out_end = 1'b1;
      default: ;
    endcase
  end

  // Grant, rr pointer and the saturating burst/idle counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) grant <= win;
        S_HEADER: begin
          if (out_ack) begin
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            burst_cnt <= burst_inc[16] ? 16'hFFFF : burst_inc[15:0];
            idle_cnt  <= '0;
          end else if (!g_rdy) begin
            idle_cnt  <= idle_inc[16] ? 16'hFFFF : idle_inc[15:0];
          end
        end
        S_CLOSE: if (out_ack && (RR_MODE != 0)) rr_ptr <= rr_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_stream_mux.sv
// Directed bench: round-robin instance (MAX_BURST=4) driven from a vector table and
// hand sequences, plus a fixed-priority instance (MAX_BURST=3); IDLE_TIMEOUT=5 on both.
module tb_fx2_stream_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [15:0] rr_in_data;
  logic [1:0]  rr_in_rdy, rr_in_end, rr_in_ack;
  logic [7:0]  rr_out_data;
  logic        rr_out_rdy, rr_out_end, rr_out_ack, rr_busy;
  logic [3:0]  rr_out_chan;

  logic [15:0] fp_in_data;
  logic [1:0]  fp_in_rdy, fp_in_end, fp_in_ack;
  logic [7:0]  fp_out_data;
  logic        fp_out_rdy, fp_out_end, fp_out_ack, fp_busy;
  logic [3:0]  fp_out_chan;

  fx2_stream_mux #(.N_CH(2), .DW(8), .MAX_BURST(4), .IDLE_TIMEOUT(5), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .in_data(rr_in_data), .in_rdy(rr_in_rdy), .in_end(rr_in_end),
    .in_ack(rr_in_ack), .out_data(rr_out_data), .out_rdy(rr_out_rdy), .out_end(rr_out_end),
    .out_ack(rr_out_ack), .out_chan(rr_out_chan), .busy(rr_busy)
  );

  fx2_stream_mux #(.N_CH(2), .DW(8), .MAX_BURST(3), .IDLE_TIMEOUT(5), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .in_data(fp_in_data), .in_rdy(fp_in_rdy), .in_end(fp_in_end),
    .in_ack(fp_in_ack), .out_data(fp_out_data), .out_rdy(fp_out_rdy), .out_end(fp_out_end),
    .out_ack(fp_out_ack), .out_chan(fp_out_chan), .busy(fp_busy)
  );

  typedef struct {
    logic [1:0] rdy;
    logic [1:0] eop;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
    logic       x_rdy;
    logic       x_end;
    logic [7:0] x_data;
    logic [1:0] x_ack;
    logic       x_busy;
    logic [3:0] x_chan;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic [1:0] rdy, input logic [1:0] eop, input logic [7:0] d0,
                              input logic [7:0] d1, input logic ack, input logic x_rdy,
                              input logic x_end, input logic [7:0] x_data, input logic [1:0] x_ack,
                              input logic x_busy, input logic [3:0] x_chan);
    vec_t v;
    v.rdy = rdy; v.eop = eop; v.d0 = d0; v.d1 = d1; v.ack = ack;
    v.x_rdy = x_rdy; v.x_end = x_end; v.x_data = x_data; v.x_ack = x_ack;
    v.x_busy = x_busy; v.x_chan = x_chan;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drv(input logic [1:0] rdy, input logic [1:0] eop, input logic [7:0] d0,
                     input logic [7:0] d1, input logic ack);
    rr_in_rdy  = rdy;
    rr_in_end  = eop;
    rr_in_data = {d1, d0};
    rr_out_ack = ack;
    #1;
  endtask

  task automatic chk_rr(input string tag, input int idx, input logic ordy, input logic oend,
                        input logic [7:0] data, input logic [1:0] iack, input logic bsy,
                        input logic [3:0] chan);
    chk({tag, ".out_rdy"},  idx, 16'(rr_out_rdy),  16'(ordy));
    chk({tag, ".out_end"},  idx, 16'(rr_out_end),  16'(oend));
    chk({tag, ".out_data"}, idx, 16'(rr_out_data), 16'(data));
    chk({tag, ".in_ack"},   idx, 16'(rr_in_ack),   16'(iack));
    chk({tag, ".busy"},     idx, 16'(rr_busy),     16'(bsy));
    chk({tag, ".out_chan"}, idx, 16'(rr_out_chan), 16'(chan));
  endtask

  task automatic chk_fp(input int idx, input logic ordy, input logic oend, input logic [7:0] data,
                        input logic [1:0] iack, input logic bsy, input logic [3:0] chan);
    chk("fp.out_rdy",  idx, 16'(fp_out_rdy),  16'(ordy));
    chk("fp.out_end",  idx, 16'(fp_out_end),  16'(oend));
    chk("fp.out_data", idx, 16'(fp_out_data), 16'(data));
    chk("fp.in_ack",   idx, 16'(fp_in_ack),   16'(iack));
    chk("fp.busy",     idx, 16'(fp_busy),     16'(bsy));
    chk("fp.out_chan", idx, 16'(fp_out_chan), 16'(chan));
  endtask

  initial begin
    // ch0 4-byte record, end on the MAX_BURST-th byte -> one CLOSE
    tbl.push_back(mk(2'b01, 2'b00, 8'h01, 8'h00, 1, 0, 0, 8'h00, 2'b00, 0, 0));
    tbl.push_back(mk(2'b01, 2'b00, 8'h01, 8'h00, 1, 1, 0, 8'hA0, 2'b00, 1, 0));
    tbl.push_back(mk(2'b01, 2'b00, 8'h01, 8'h00, 1, 1, 0, 8'h01, 2'b01, 1, 0));
    tbl.push_back(mk(2'b01, 2'b00, 8'h02, 8'h00, 1, 1, 0, 8'h02, 2'b01, 1, 0));
    tbl.push_back(mk(2'b01, 2'b00, 8'h03, 8'h00, 1, 1, 0, 8'h03, 2'b01, 1, 0));
    tbl.push_back(mk(2'b01, 2'b01, 8'h04, 8'h00, 1, 1, 0, 8'h04, 2'b01, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 1, 8'h00, 2'b00, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 2'b00, 0, 0));
    // both ready, rr pointer now 1: ch1 burst of 4, then ch0 burst of 4
    tbl.push_back(mk(2'b11, 2'b00, 8'h11, 8'h21, 1, 0, 0, 8'h00, 2'b00, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 8'h11, 8'h21, 1, 1, 0, 8'hA1, 2'b00, 1, 1));
    tbl.push_back(mk(2'b11, 2'b00, 8'h11, 8'h21, 1, 1, 0, 8'h21, 2'b10, 1, 1));
    tbl.push_back(mk(2'b11, 2'b00, 8'h11, 8'h22, 1, 1, 0, 8'h22, 2'b10, 1, 1));
    tbl.push_back(mk(2'b11, 2'b00, 8'h11, 8'h23, 1, 1, 0, 8'h23, 2'b10, 1, 1));
    tbl.push_back(mk(2'b11, 2'b00, 8'h11, 8'h24, 1, 1, 0, 8'h24, 2'b10, 1, 1));
    tbl.push_back(mk(2'b11, 2'b00, 8'h11, 8'h25, 1, 0, 1, 8'h00, 2'b00, 1, 1));
    tbl.push_back(mk(2'b11, 2'b00, 8'h11, 8'h25, 1, 0, 0, 8'h00, 2'b00, 0, 1));
    tbl.push_back(mk(2'b11, 2'b00, 8'h11, 8'h25, 1, 1, 0, 8'hA0, 2'b00, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 8'h11, 8'h25, 1, 1, 0, 8'h11, 2'b01, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 8'h12, 8'h25, 1, 1, 0, 8'h12, 2'b01, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 8'h13, 8'h25, 1, 1, 0, 8'h13, 2'b01, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 8'h14, 8'h25, 1, 1, 0, 8'h14, 2'b01, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 8'h15, 8'h25, 1, 0, 1, 8'h00, 2'b00, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 8'h15, 8'h25, 1, 0, 0, 8'h00, 2'b00, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 8'h15, 8'h25, 1, 1, 0, 8'hA1, 2'b00, 1, 1));
    // out_ack toggling in STREAM; end byte 27 closes early; CLOSE holds without ack
    tbl.push_back(mk(2'b11, 2'b00, 8'h15, 8'h25, 0, 1, 0, 8'h25, 2'b00, 1, 1));
    tbl.push_back(mk(2'b11, 2'b00, 8'h15, 8'h25, 1, 1, 0, 8'h25, 2'b10, 1, 1));
    tbl.push_back(mk(2'b11, 2'b00, 8'h15, 8'h26, 0, 1, 0, 8'h26, 2'b00, 1, 1));
    tbl.push_back(mk(2'b11, 2'b00, 8'h15, 8'h26, 1, 1, 0, 8'h26, 2'b10, 1, 1));
    tbl.push_back(mk(2'b11, 2'b10, 8'h15, 8'h27, 1, 1, 0, 8'h27, 2'b10, 1, 1));
    tbl.push_back(mk(2'b11, 2'b00, 8'h15, 8'h28, 0, 0, 1, 8'h00, 2'b00, 1, 1));
    tbl.push_back(mk(2'b11, 2'b00, 8'h15, 8'h28, 1, 0, 1, 8'h00, 2'b00, 1, 1));
    tbl.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 2'b00, 0, 1));

    reset      = 1'b1;
    fp_in_rdy  = 2'b00;
    fp_in_end  = 2'b00;
    fp_in_data = {8'h60, 8'h50};
    fp_out_ack = 1'b1;
    drv(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    chk_rr("reset", 0, 0, 0, 8'h00, 2'b00, 0, 0);
    chk_fp(0, 0, 0, 8'h00, 2'b00, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drv(tbl[i].rdy, tbl[i].eop, tbl[i].d0, tbl[i].d1, tbl[i].ack);
      chk_rr("vec", i, tbl[i].x_rdy, tbl[i].x_end, tbl[i].x_data, tbl[i].x_ack,
             tbl[i].x_busy, tbl[i].x_chan);
      @(negedge clk);
    end

    // idle timeout: ch1 sends 2 bytes then stalls for exactly 5 cycles
    drv(2'b10, 2'b00, 8'h00, 8'h31, 1); chk_rr("tmo", 0, 0, 0, 8'h00, 2'b00, 0, 1); @(negedge clk);
    drv(2'b10, 2'b00, 8'h00, 8'h31, 1); chk_rr("tmo", 1, 1, 0, 8'hA1, 2'b00, 1, 1); @(negedge clk);
    drv(2'b10, 2'b00, 8'h00, 8'h31, 1); chk_rr("tmo", 2, 1, 0, 8'h31, 2'b10, 1, 1); @(negedge clk);
    drv(2'b10, 2'b00, 8'h00, 8'h32, 1); chk_rr("tmo", 3, 1, 0, 8'h32, 2'b10, 1, 1); @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      drv(2'b00, 2'b00, 8'h00, 8'h32, 1);
      chk_rr("tmo", 4 + k, 0, 0, 8'h32, 2'b00, 1, 1);
      @(negedge clk);
    end
    drv(2'b00, 2'b00, 8'h00, 8'h32, 1); chk_rr("tmo", 9, 0, 1, 8'h00, 2'b00, 1, 1); @(negedge clk);
    drv(2'b10, 2'b10, 8'h00, 8'h33, 1); chk_rr("tmo", 10, 0, 0, 8'h00, 2'b00, 0, 1); @(negedge clk);
    drv(2'b10, 2'b10, 8'h00, 8'h33, 1); chk_rr("tmo", 11, 1, 0, 8'hA1, 2'b00, 1, 1); @(negedge clk);
    drv(2'b10, 2'b10, 8'h00, 8'h33, 1); chk_rr("tmo", 12, 1, 0, 8'h33, 2'b10, 1, 1); @(negedge clk);
    drv(2'b00, 2'b00, 8'h00, 8'h00, 1); chk_rr("tmo", 13, 0, 1, 8'h00, 2'b00, 1, 1); @(negedge clk);

    // reset mid-STREAM with rr pointer at 1; afterwards ch0 must win again
    drv(2'b01, 2'b00, 8'h41, 8'h00, 1); chk_rr("rst", 0, 0, 0, 8'h00, 2'b00, 0, 1); @(negedge clk);
    drv(2'b01, 2'b01, 8'h41, 8'h00, 1); chk_rr("rst", 1, 1, 0, 8'hA0, 2'b00, 1, 0); @(negedge clk);
    drv(2'b01, 2'b01, 8'h41, 8'h00, 1); chk_rr("rst", 2, 1, 0, 8'h41, 2'b01, 1, 0); @(negedge clk);
    drv(2'b00, 2'b00, 8'h00, 8'h00, 1); chk_rr("rst", 3, 0, 1, 8'h00, 2'b00, 1, 0); @(negedge clk);
    drv(2'b10, 2'b00, 8'h00, 8'h51, 1); chk_rr("rst", 4, 0, 0, 8'h00, 2'b00, 0, 0); @(negedge clk);
    drv(2'b10, 2'b00, 8'h00, 8'h51, 1); chk_rr("rst", 5, 1, 0, 8'hA1, 2'b00, 1, 1); @(negedge clk);
    drv(2'b10, 2'b00, 8'h00, 8'h51, 1); chk_rr("rst", 6, 1, 0, 8'h51, 2'b10, 1, 1); @(negedge clk);
    drv(2'b10, 2'b00, 8'h00, 8'h52, 1); chk_rr("rst", 7, 1, 0, 8'h52, 2'b10, 1, 1); @(negedge clk);
    reset = 1'b1;
    drv(2'b11, 2'b00, 8'h61, 8'h53, 1); chk_rr("rst", 8, 1, 0, 8'h53, 2'b10, 1, 1); @(negedge clk);
    drv(2'b11, 2'b00, 8'h61, 8'h53, 1); chk_rr("rst", 9, 0, 0, 8'h00, 2'b00, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    drv(2'b11, 2'b00, 8'h61, 8'h53, 1); chk_rr("rst", 10, 1, 0, 8'hA0, 2'b00, 1, 0); @(negedge clk);
    drv(2'b11, 2'b01, 8'h61, 8'h53, 1); chk_rr("rst", 11, 1, 0, 8'h61, 2'b01, 1, 0); @(negedge clk);
    drv(2'b00, 2'b00, 8'h00, 8'h00, 1); chk_rr("rst", 12, 0, 1, 8'h00, 2'b00, 1, 0); @(negedge clk);

    // fixed priority: ch0 keeps winning; ch1 served only after ch0 drops and times out
    fp_in_rdy = 2'b11;
    #1; chk_fp(1, 0, 0, 8'h00, 2'b00, 0, 0); @(negedge clk);
    #1; chk_fp(2, 1, 0, 8'hA0, 2'b00, 1, 0); @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1; chk_fp(3 + k, 1, 0, 8'h50, 2'b01, 1, 0); @(negedge clk);
    end
    #1; chk_fp(6, 0, 1, 8'h00, 2'b00, 1, 0); @(negedge clk);
    #1; chk_fp(7, 0, 0, 8'h00, 2'b00, 0, 0); @(negedge clk);
    #1; chk_fp(8, 1, 0, 8'hA0, 2'b00, 1, 0); @(negedge clk);
    #1; chk_fp(9, 1, 0, 8'h50, 2'b01, 1, 0); @(negedge clk);
    fp_in_rdy = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1; chk_fp(10 + k, 0, 0, 8'h50, 2'b00, 1, 0); @(negedge clk);
    end
    #1; chk_fp(15, 0, 1, 8'h00, 2'b00, 1, 0); @(negedge clk);
    #1; chk_fp(16, 0, 0, 8'h00, 2'b00, 0, 0); @(negedge clk);
    #1; chk_fp(17, 1, 0, 8'hA1, 2'b00, 1, 1); @(negedge clk);
    #1; chk_fp(18, 1, 0, 8'h60, 2'b10, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
